// File: rtl/calc_key_pkg.sv
// Shared keypad definitions: key code type, operator code constants and the
// keypad index -> calculator code map used when KEY_MAP_EN is defined.
package calc_key_pkg;

   typedef logic [3:0] key_code_t;

   localparam key_code_t KEY_ADD = 4'hA;
   localparam key_code_t KEY_SUB = 4'hB;
   localparam key_code_t KEY_MUL = 4'hC;
   localparam key_code_t KEY_DIV = 4'hD;
   localparam key_code_t KEY_EQ  = 4'hE;
   localparam key_code_t KEY_CLR = 4'hF;

   // Row-major 4x4 keypad layout: 1 2 3 + / 4 5 6 - / 7 8 9 * / C 0 = /
   function automatic key_code_t key_map(input logic [3:0] idx);
      key_code_t code;
      case (idx)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = KEY_ADD;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = KEY_SUB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = KEY_MUL;
         4'd12:   code = KEY_CLR;
         4'd13:   code = 4'h0;
         4'd14:   code = KEY_EQ;
         default: code = KEY_DIV;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// Keypad event bus: scanner pulses in, buffered key codes out over
// valid/ready, plus level and sticky overflow status.
// master = encoder side, slave = calculator core / scanner side.
interface key_event_encoder_if #(
   parameter int ADDR_W = 2
);
   import calc_key_pkg::*;

   logic [15:0]     key_pulse;
   key_code_t       key_code;
   logic            key_valid;
   logic            key_ready;
   logic [ADDR_W:0] fifo_level;
   logic            overflow;
   logic            ovf_clr;

   modport master (
      input  key_pulse,
      input  key_ready,
      input  ovf_clr,
      output key_code,
      output key_valid,
      output fifo_level,
      output overflow
   );

   modport slave (
      output key_pulse,
      output key_ready,
      output ovf_clr,
      input  key_code,
      input  key_valid,
      input  fifo_level,
      input  overflow
   );

endinterface

// File: rtl/key_code_fifo.sv
// Synchronous FIFO of key codes with occupancy output. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module key_code_fifo
   import calc_key_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  key_code_t       wr_data,
   input  logic            rd_en,
   output key_code_t       rd_data,
   output logic            empty,
   output logic            full,
   output logic [ADDR_W:0] level
);

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   key_code_t       mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic            do_wr;
   logic            do_rd;

   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign level   = wr_ptr - rd_ptr;
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

   // Storage is cleared on reset so the head reads 0 while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
            wr_ptr                  <= wr_ptr + PTR_ONE;
         end
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/key_event_encoder.sv
// Keypad event encoder: latches one-clock key pulses into a pending vector,
// drains it lowest index first into a key code FIFO, one code per cycle.
// Build option: define KEY_MAP_EN to store calculator codes instead of raw
// key indices.
module key_event_encoder
   import calc_key_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   key_event_encoder_if.master bus
);

   logic [15:0] pending;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   key_code_t   wr_code;
   logic        fifo_full;
   logic        fifo_empty;
   logic        ovf_event;

   // Lowest pending key wins; nothing is granted while the FIFO is full so
   // the bit simply waits in pending.
   always_comb begin
      grant = '0;
      if (!fifo_full) grant = pending & (~pending + 16'd1);
   end

   // Index of the lowest pending bit (only used when grant is non-zero).
   always_comb begin
      grant_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (pending[i]) grant_idx = 4'(i);
      end
   end

`ifdef KEY_MAP_EN
   assign wr_code = key_map(grant_idx);
`else
   assign wr_code = grant_idx;
`endif

   // A repeat press of a key still waiting in pending is merged and flagged.
   assign ovf_event = |(bus.key_pulse & pending & ~grant);

   // Pending vector: retire the granted bit, absorb new pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~grant) | bus.key_pulse;
   end

   // Sticky overflow; a new event in the clearing cycle keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         bus.overflow <= 1'b0;
      else if (ovf_event) bus.overflow <= 1'b1;
      else if (bus.ovf_clr) bus.overflow <= 1'b0;
   end

   key_code_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (|grant),
      .wr_data (wr_code),
      .rd_en   (bus.key_ready),
      .rd_data (bus.key_code),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (bus.fifo_level)
   );

   assign bus.key_valid = ~fifo_empty;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder. Expected codes are queued when
// pulses are driven and compared when the consumer accepts them.
module tb_key_event_encoder;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q [$];

   key_event_encoder_if #(.ADDR_W(2)) bus ();

   key_event_encoder #(
      .FIFO_DEPTH (4),
      .ADDR_W     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_code(input int idx);
      logic [3:0] c;
`ifdef KEY_MAP_EN
      case (idx)
         0: c = 4'h1;   1: c = 4'h2;   2: c = 4'h3;   3: c = 4'hA;
         4: c = 4'h4;   5: c = 4'h5;   6: c = 4'h6;   7: c = 4'hB;
         8: c = 4'h7;   9: c = 4'h8;  10: c = 4'h9;  11: c = 4'hC;
        12: c = 4'hF;  13: c = 4'h0;  14: c = 4'hE;
         default: c = 4'hD;
      endcase
`else
      c = 4'(idx);
`endif
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample the head, compare against the scoreboard, then accept it.
   task automatic pop_and_check(input string name);
      logic [3:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got code %h but nothing expected", name, bus.key_code);
      end else begin
         e = exp_q.pop_front();
         if (bus.key_valid !== 1'b1 || bus.key_code !== e) begin
            errors++;
            $display("FAIL %s: valid=%b code=%h, required valid=1 code=%h",
                     name, bus.key_valid, bus.key_code, e);
         end
      end
      bus.key_ready = 1'b1;
      step();
      bus.key_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.key_pulse = '0;
      bus.key_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
      #12;
      checks++;
      if (bus.key_valid !== 1'b0 || bus.key_code !== 4'h0 ||
          bus.fifo_level !== 3'd0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b code=%h level=%0d ovf=%b, required 0/0/0/0",
                  bus.key_valid, bus.key_code, bus.fifo_level, bus.overflow);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      bus.key_pulse = 16'h0020;
      exp_q.push_back(exp_code(5));
      step();
      bus.key_pulse = '0;
      checks++;
      if (bus.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency: valid=%b one cycle after pulse, required 0", bus.key_valid);
      end
      step();
      checks++;
      if (bus.fifo_level !== 3'd1) begin
         errors++;
         $display("FAIL single_level: level=%0d, required 1", bus.fifo_level);
      end
      pop_and_check("single_code");
      checks++;
      if (bus.fifo_level !== 3'd0 || bus.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: level=%0d valid=%b, required 0/0", bus.fifo_level, bus.key_valid);
      end
   endtask

   task automatic test_multi();
      bus.key_pulse = 16'h0109;
      exp_q.push_back(exp_code(0));
      exp_q.push_back(exp_code(3));
      exp_q.push_back(exp_code(8));
      step();
      bus.key_pulse = '0;
      for (int n = 1; n <= 3; n++) begin
         step();
         checks++;
         if (bus.fifo_level !== 3'(n)) begin
            errors++;
            $display("FAIL multi_level: level=%0d, required %0d", bus.fifo_level, n);
         end
      end
      step();
      checks++;
      if (bus.fifo_level !== 3'd3) begin
         errors++;
         $display("FAIL multi_hold: level=%0d, required 3", bus.fifo_level);
      end
      for (int n = 0; n < 3; n++) pop_and_check("multi_code");
   endtask

   task automatic test_full_overflow();
      int idx [5] = '{1, 2, 4, 6, 9};
      for (int n = 0; n < 5; n++) begin
         bus.key_pulse = 16'h0001 << idx[n];
         exp_q.push_back(exp_code(idx[n]));
         step();
      end
      bus.key_pulse = '0;
      step(); step(); step();
      checks++;
      if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_level: level=%0d ovf=%b, required 4/0", bus.fifo_level, bus.overflow);
      end
      // repeat key 9 while it is still waiting
      bus.key_pulse = 16'h0200;
      step();
      bus.key_pulse = '0;
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: ovf=%b, required 1", bus.overflow);
      end
      step();
      checks++;
      if (bus.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: ovf=%b, required 1", bus.overflow);
      end
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: ovf=%b, required 0", bus.overflow);
      end
      pop_and_check("full_code");
      checks++;
      if (bus.fifo_level !== 3'd3) begin
         errors++;
         $display("FAIL full_read: level=%0d, required 3", bus.fifo_level);
      end
      step();
      checks++;
      if (bus.fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL full_refill: level=%0d, required 4", bus.fifo_level);
      end
      for (int n = 0; n < 4; n++) pop_and_check("full_code");
      step(); step(); step();
      checks++;
      if (bus.key_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL no_duplicate: valid=%b level=%0d code=%h, required 0/0",
                  bus.key_valid, bus.fifo_level, bus.key_code);
      end
   endtask

   task automatic test_reset_mid();
      bus.key_pulse = 16'h0003;
      step();
      bus.key_pulse = '0;
      step(); step();
      checks++;
      if (bus.fifo_level !== 3'd2) begin
         errors++;
         $display("FAIL mid_setup: level=%0d, required 2", bus.fifo_level);
      end
      bus.key_pulse = 16'h0300;
      step();
      bus.key_pulse = '0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.key_valid !== 1'b0 || bus.key_code !== 4'h0 ||
          bus.fifo_level !== 3'd0 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b code=%h level=%0d ovf=%b, required 0/0/0/0",
                  bus.key_valid, bus.key_code, bus.fifo_level, bus.overflow);
      end
      step(); step();
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         checks++;
         if (bus.key_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_release: valid=%b level=%0d, required 0/0",
                     bus.key_valid, bus.fifo_level);
         end
      end
   endtask

   task automatic test_back_to_back();
      int received = 0;
      int cyc = 0;
      logic [3:0] e;
      bus.key_ready = 1'b1;
      while ((cyc < 20 || exp_q.size() != 0) && cyc < 60) begin
         if (bus.key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rotation_extra: code=%h with nothing expected", bus.key_code);
            end else begin
               e = exp_q.pop_front();
               received++;
               if (bus.key_code !== e) begin
                  errors++;
                  $display("FAIL rotation_code: got %h, required %h", bus.key_code, e);
               end
            end
         end
         if (cyc >= 6 && cyc < 20) begin
            checks++;
            if (bus.fifo_level !== 3'd1) begin
               errors++;
               $display("FAIL rotation_level: level=%0d, required 1", bus.fifo_level);
            end
         end
         if (cyc < 20) begin
            bus.key_pulse = 16'h0001 << ((cyc * 5 + 3) % 16);
            exp_q.push_back(exp_code((cyc * 5 + 3) % 16));
         end else begin
            bus.key_pulse = '0;
         end
         step();
         cyc++;
      end
      bus.key_ready = 1'b0;
      bus.key_pulse = '0;
      checks++;
      if (received != 20 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rotation_count: received %0d, required 20 (left %0d)",
                  received, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_full_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
